// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - execute-stage sequencer: decodes a request, drives the ALU, returns the result
// Optional: ALU_SEQ_BRANCH_EN enables BEQ/BNE decode and rsp_taken.
module alu_issue_seq #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        req_opcode,
  input  logic [2:0]        req_funct3,
  input  logic              req_funct7b5,
  input  logic [DATA_W-1:0] req_rs1,
  input  logic [DATA_W-1:0] req_rs2,
  input  logic [DATA_W-1:0] req_imm,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_taken,
  output logic              rsp_illegal
);

  localparam logic [OP_W-1:0] ALU_AND = OP_W'(4'b0000);
  localparam logic [OP_W-1:0] ALU_OR  = OP_W'(4'b0001);
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(4'b0010);
  localparam logic [OP_W-1:0] ALU_SUB = OP_W'(4'b0110);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic [OP_W-1:0]   w_op;
  logic              w_use_imm;
  logic              w_illegal;
  logic [DATA_W-1:0] r_alu_op1;
  logic [DATA_W-1:0] r_alu_op2;
  logic [OP_W-1:0]   r_alu_op;
  logic              r_illegal;
  logic [DATA_W-1:0] r_rsp_result;
  logic              r_rsp_illegal;
`ifdef ALU_SEQ_BRANCH_EN
  logic              w_is_br;
  logic              w_br_ne;
  logic              r_is_br;
  logic              r_br_ne;
  logic              r_rsp_taken;
`else
  logic              w_unused_zero;
  assign w_unused_zero = alu_zero;
`endif

  always_comb begin
    w_op      = ALU_AND;
    w_use_imm = 1'b0;
    w_illegal = 1'b0;
`ifdef ALU_SEQ_BRANCH_EN
    w_is_br   = 1'b0;
    w_br_ne   = 1'b0;
`endif
    case (req_opcode)
      7'b0110011: begin
        case (req_funct3)
          3'b000:  w_op = req_funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  w_op = ALU_AND;
          3'b110:  w_op = ALU_OR;
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0010011: begin
        w_use_imm = 1'b1;
        case (req_funct3)
          3'b000:  w_op = ALU_ADD;
          3'b111:  w_op = ALU_AND;
          3'b110:  w_op = ALU_OR;
          default: w_illegal = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: begin
        w_use_imm = 1'b1;
        w_op      = ALU_ADD;
      end
`ifdef ALU_SEQ_BRANCH_EN
      7'b1100011: begin
        w_op    = ALU_SUB;
        w_is_br = 1'b1;
        if (req_funct3 == 3'b001) w_br_ne = 1'b1;
        else if (req_funct3 != 3'b000) w_illegal = 1'b1;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Illegal requests present zero operands and AND so the ALU sees a quiet, known input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op1     <= '0;
      r_alu_op2     <= '0;
      r_alu_op      <= ALU_AND;
      r_illegal     <= 1'b0;
      r_rsp_result  <= '0;
      r_rsp_illegal <= 1'b0;
`ifdef ALU_SEQ_BRANCH_EN
      r_is_br       <= 1'b0;
      r_br_ne       <= 1'b0;
      r_rsp_taken   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_alu_op1 <= w_illegal ? '0 : req_rs1;
        r_alu_op2 <= w_illegal ? '0 : (w_use_imm ? req_imm : req_rs2);
        r_alu_op  <= w_illegal ? ALU_AND : w_op;
        r_illegal <= w_illegal;
`ifdef ALU_SEQ_BRANCH_EN
        r_is_br   <= w_is_br && !w_illegal;
        r_br_ne   <= w_br_ne;
`endif
      end
      if (r_state == EXEC) begin
        r_rsp_result  <= r_illegal ? '0 : alu_result;
        r_rsp_illegal <= r_illegal;
`ifdef ALU_SEQ_BRANCH_EN
        r_rsp_taken   <= r_is_br && (alu_zero ^ r_br_ne);
`endif
      end
    end
  end

  assign alu_op1     = r_alu_op1;
  assign alu_op2     = r_alu_op2;
  assign alu_op      = r_alu_op;
  assign rsp_result  = r_rsp_result;
  assign rsp_illegal = r_rsp_illegal;
`ifdef ALU_SEQ_BRANCH_EN
  assign rsp_taken   = r_rsp_taken;
`else
  assign rsp_taken   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq with a behavioural ALU and decode model
module tb_alu_issue_seq;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic        taken;
    logic        ill;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_opcode = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_funct7b5 = 1'b0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_imm = '0;
  logic [31:0] alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_taken, rsp_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_op == 4'b0000) ? (alu_op1 & alu_op2) :
                      (alu_op == 4'b0001) ? (alu_op1 | alu_op2) :
                      (alu_op == 4'b0010) ? (alu_op1 + alu_op2) :
                      (alu_op == 4'b0110) ? (alu_op1 - alu_op2) : 32'h0;
  assign alu_zero = (alu_result == 32'h0);

  alu_issue_seq #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal)
  );

  // Mnemonic-level reference: 0 add, 1 sub, 2 and, 3 or, -1 illegal.
  function automatic rec_t model(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    rec_t e;
    int m;
    logic [31:0] y;
    e = '0;
    m = -1;
    y = b;
    case (opc)
      7'h33: m = (f3 == 3'd0) ? (f7 ? 1 : 0) : (f3 == 3'd7) ? 2 : (f3 == 3'd6) ? 3 : -1;
      7'h13: begin y = imm; m = (f3 == 3'd0) ? 0 : (f3 == 3'd7) ? 2 : (f3 == 3'd6) ? 3 : -1; end
      7'h03, 7'h23: begin y = imm; m = 0; end
`ifdef ALU_SEQ_BRANCH_EN
      7'h63: if (f3 < 3'd2) begin m = 1; e.taken = (f3 == 3'd0) ? (a == b) : (a != b); end
`endif
      default: m = -1;
    endcase
    if (m < 0) begin
      e.ill = 1'b1;
      return e;
    end
    e.op1 = a;
    e.op2 = y;
    case (m)
      0: begin e.op = 4'b0010; e.res = a + y; end
      1: begin e.op = 4'b0110; e.res = a - y; end
      2: begin e.op = 4'b0000; e.res = a & y; end
      default: begin e.op = 4'b0001; e.res = a | y; end
    endcase
    return e;
  endfunction

  task automatic drive_req(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    req_valid = 1'b1; req_opcode = opc; req_funct3 = f3; req_funct7b5 = f7;
    req_rs1 = a; req_rs2 = b; req_imm = imm;
  endtask

  // Issues one instruction with rsp_ready high; returns observed ALU inputs, response and latency.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                           output rec_t obs, output int lat, output bit to);
    int w;
    obs = '0; lat = 0; to = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(opc, f3, f7, a, b, imm);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin to = 1'b1; req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    obs.op = alu_op; obs.op1 = alu_op1; obs.op2 = alu_op2;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!rsp_valid) to = 1'b1;
    obs.res = rsp_result; obs.taken = rsp_taken; obs.ill = rsp_illegal;
    @(posedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal, alu_op1, alu_op2, alu_op} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h tk=%b il=%b op1=%h op2=%h op=%h", req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal, alu_op1, alu_op2, alu_op);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    rec_t o; int lat; bit to;
    run_instr(7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'hDEAD, o, lat, to);
    n_vec++; if (to !== 1'b0) begin n_err++; $display("FAIL add_timeout: got %b want 0", to); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d want 2", lat); end
    n_vec++; if (o.op !== 4'b0010) begin n_err++; $display("FAIL add_op: got %b want 0010", o.op); end
    n_vec++; if (o.res !== 32'd12) begin n_err++; $display("FAIL add_result: got %0d want 12", o.res); end
    n_vec++; if (o.ill !== 1'b0) begin n_err++; $display("FAIL add_illegal: got %b want 0", o.ill); end
  endtask

  task automatic test_branch();
    rec_t o; int lat; bit to;
    for (int k = 0; k < 2; k++) begin
      run_instr(7'h63, 3'(k), 1'b0, 32'h1234, 32'h1234, 32'h0, o, lat, to);
`ifdef ALU_SEQ_BRANCH_EN
      n_vec++; if (o.op !== 4'b0110) begin n_err++; $display("FAIL branch_op f3=%0d: got %b want 0110", k, o.op); end
      n_vec++; if (o.res !== 32'h0) begin n_err++; $display("FAIL branch_result f3=%0d: got %h want 0", k, o.res); end
      n_vec++; if (o.taken !== (k == 0)) begin n_err++; $display("FAIL branch_taken f3=%0d: got %b want %b", k, o.taken, k == 0); end
      n_vec++; if (o.ill !== 1'b0) begin n_err++; $display("FAIL branch_illegal f3=%0d: got %b want 0", k, o.ill); end
`else
      n_vec++; if (o.ill !== 1'b1) begin n_err++; $display("FAIL branch_disabled_illegal f3=%0d: got %b want 1", k, o.ill); end
      n_vec++; if (o.op !== 4'b0000 || o.taken !== 1'b0) begin n_err++; $display("FAIL branch_disabled_op f3=%0d: got op=%b tk=%b want 0000/0", k, o.op, o.taken); end
`endif
    end
  endtask

  task automatic test_logic_imm();
    rec_t o; int lat; bit to;
    run_instr(7'h13, 3'd7, 1'b1, 32'hF0F0, $urandom, 32'h0FF0, o, lat, to);
    n_vec++; if (o.res !== 32'h00F0) begin n_err++; $display("FAIL andi_result: got %h want 000000f0", o.res); end
    n_vec++; if (o.op2 !== 32'h0FF0) begin n_err++; $display("FAIL andi_op2: got %h want 00000ff0", o.op2); end
    run_instr(7'h13, 3'd6, 1'b0, 32'hF0F0, $urandom, 32'h0FF0, o, lat, to);
    n_vec++; if (o.res !== 32'hFFF0) begin n_err++; $display("FAIL ori_result: got %h want 0000fff0", o.res); end
    n_vec++; if (o.op !== 4'b0001) begin n_err++; $display("FAIL ori_op: got %b want 0001", o.op); end
  endtask

  task automatic test_illegal();
    rec_t o; int lat; bit to;
    run_instr(7'h7F, 3'd0, 1'b0, 32'h1111, 32'h2222, 32'h3333, o, lat, to);
    n_vec++; if (o.ill !== 1'b1) begin n_err++; $display("FAIL illegal_flag: got %b want 1", o.ill); end
    n_vec++; if (o.res !== 32'h0 || o.op !== 4'b0000) begin n_err++; $display("FAIL illegal_outputs: got res=%h op=%b want 0/0000", o.res, o.op); end
    n_vec++; if (o.op1 !== 32'h0 || o.op2 !== 32'h0) begin n_err++; $display("FAIL illegal_operands: got %h %h want 0 0", o.op1, o.op2); end
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL illegal_latency: got %0d want 2", lat); end
  endtask

  task automatic test_random();
    rec_t o, e; int lat; bit to;
    logic [6:0] opc; logic [2:0] f3; logic f7; logic [31:0] a, b, imm;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: opc = 7'h33;
        1: opc = 7'h13;
        2: opc = 7'h03;
        3: opc = 7'h23;
        4: opc = 7'h63;
        default: opc = 7'($urandom);
      endcase
      f3 = 3'($urandom); f7 = 1'($urandom);
      a = $urandom; b = $urandom; imm = $urandom;
      if ($urandom_range(0, 1) == 1) b = a;
      e = model(opc, f3, f7, a, b, imm);
      run_instr(opc, f3, f7, a, b, imm, o, lat, to);
      n_vec++;
      if (to !== 1'b0 || lat !== 2 || o !== e) begin
        n_err++;
        $display("FAIL random[%0d] opc=%h f3=%0d f7=%b: got op=%b op1=%h op2=%h res=%h tk=%b il=%b lat=%0d want op=%b op1=%h op2=%h res=%h tk=%b il=%b lat=2",
                 i, opc, f3, f7, o.op, o.op1, o.op2, o.res, o.taken, o.ill, lat, e.op, e.op1, e.op2, e.res, e.taken, e.ill);
      end
    end
  endtask

  task automatic test_backpressure();
    rec_t eb; logic [31:0] res0; int w;
    logic [31:0] ba, bb;
    ba = $urandom; bb = $urandom;
    eb = model(7'h33, 3'd0, 1'b1, ba, bb, 32'h0);
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(7'h33, 3'd0, 1'b0, 32'd100, 32'd23, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive_req(7'h33, 3'd0, 1'b1, ba, bb, 32'h0);
    @(negedge clk);
    res0 = rsp_result;
    n_vec++; if (rsp_valid !== 1'b1 || res0 !== 32'd123) begin n_err++; $display("FAIL bp_first_rsp: got vld=%b res=%0d want 1/123", rsp_valid, res0); end
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd123 || req_ready !== 1'b0 || rsp_illegal !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld=%b res=%0d rdy=%b il=%b want 1/123/0/0", c, rsp_valid, rsp_result, req_ready, rsp_illegal);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle_after_hs: got rdy=%b vld=%b want 1/0", req_ready, rsp_valid); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (req_ready !== 1'b0 || alu_op !== eb.op || alu_op1 !== ba || alu_op2 !== bb) begin
      n_err++; $display("FAIL bp_queued_accept: got rdy=%b op=%b op1=%h op2=%h want 0/%b/%h/%h", req_ready, alu_op, alu_op1, alu_op2, eb.op, ba, bb);
    end
    w = 0;
    while (!rsp_valid && w < 20) begin @(negedge clk); w++; end
    n_vec++; if (rsp_valid !== 1'b1 || rsp_result !== eb.res) begin n_err++; $display("FAIL bp_queued_rsp: got vld=%b res=%h want 1/%h", rsp_valid, rsp_result, eb.res); end
    @(posedge clk);
  endtask

  task automatic test_reset_in_exec();
    rec_t o; int lat; bit to; bit seen;
    logic [31:0] a;
    a = $urandom | 32'h1;
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(7'h33, 3'd0, 1'b0, a, 32'h55, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (alu_op1 !== a) begin n_err++; $display("FAIL rst_exec_pre: got op1=%h want %h", alu_op1, a); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal, alu_op1, alu_op2, alu_op} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
      n_err++;
      $display("FAIL rst_exec_state: rdy=%b vld=%b res=%h tk=%b il=%b op1=%h op2=%h op=%h", req_ready, rsp_valid, rsp_result, rsp_taken, rsp_illegal, alu_op1, alu_op2, alu_op);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_exec_no_rsp: got rsp_valid seen=%b want 0", seen); end
    run_instr(7'h03, 3'd2, 1'b0, 32'd1000, 32'h0, 32'd24, o, lat, to);
    n_vec++; if (to !== 1'b0 || lat !== 2 || o.res !== 32'd1024 || o.op !== 4'b0010) begin
      n_err++; $display("FAIL rst_exec_after: got to=%b lat=%0d res=%0d op=%b want 0/2/1024/0010", to, lat, o.res, o.op);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_logic_imm();
    test_illegal();
    test_random();
    test_backpressure();
    test_reset_in_exec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Multi-cycle execute-stage sequencer that drives the datapath ALU. It accepts decoded instruction fields and operands over a valid/ready request port, translates opcode/funct3/funct7 into the 4-bit ALU operation code, and presents registered operands to the ALU. It captures the ALU result and Zero flag, resolves BEQ/BNE, and returns the outcome over a valid/ready response port. It sits between the decode stage and the combinational ALU, on the issuing side of the ALU operand/opcode interface.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU operation code width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_opcode  in  7  instruction[6:0]
- req_funct3  in  3  instruction[14:12]
- req_funct7b5  in  1  instruction[30]
- req_rs1, req_rs2, req_imm  in  DATA_W each  register operands, sign-extended immediate
- alu_op1, alu_op2  out  DATA_W  ALU operands (registered)
- alu_op  out  OP_W  ALU operation code (registered)
- alu_result  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_zero  in  1  ALU Zero flag
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  captured ALU result; 0 when illegal
- rsp_taken  out  1  branch taken
- rsp_illegal  out  1  unsupported encoding

## Operation
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110.
- Decode (opcode binary):
  - 0110011 R-type, op2=rs2: f3 000 with f7b5=0 ADD, f7b5=1 SUB; f3 111 AND; f3 110 OR; other f3 illegal.
  - 0010011 I-type, op2=imm: f3 000 ADD, 111 AND, 110 OR; others illegal; f7b5 ignored.
  - 0000011 load, 0100011 store: ADD, op2=imm (address); f3 ignored.
  - 1100011 branch (macro-dependent): f3 000 BEQ, 001 BNE; SUB, op2=rs2; others illegal.
  - Anything else illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. On req_valid, register op1=rs1, op2 per decode, alu_op, illegal flag, and branch kind; go to EXEC.
  - EXEC: ALU sees stable registered inputs. At the cycle end, capture alu_result and alu_zero; go to RESP.
  - RESP: rsp_valid=1 with outputs stable. On rsp_ready, go to IDLE.
- Illegal: alu_op=0000, alu_op1=alu_op2=0, rsp_result=0, rsp_illegal=1, rsp_taken=0. It still passes through EXEC.
- rsp_taken: BEQ is alu_zero, BNE is !alu_zero, non-branch is 0. rsp_result for a branch is the rs1-rs2 difference.
- alu_* outputs hold their last value in IDLE and RESP.
- No requests are accepted in EXEC or RESP. A response and a new request never overlap.

## Timing
- Accept edge N, EXEC during cycle N+1, rsp_valid high from N+2. Latency is 2 cycles; rsp_ready is sampled from N+2.
- Minimum period is 3 cycles per instruction (IDLE, EXEC, RESP).
- Backpressure: rsp_* hold indefinitely while rsp_ready=0.
- A request held during EXEC or RESP stays pending and is accepted in the first IDLE cycle.
- Reset (async assert, any state) takes effect immediately:
  - state=IDLE, req_ready=1
  - rsp_valid=0, rsp_result=0, rsp_taken=0, rsp_illegal=0
  - alu_op1=0, alu_op2=0, alu_op=0000
  - An in-flight instruction is dropped with no response.
- Reset deassertion is synchronous to clk externally. The first accept can happen on the first rising edge after release.

## Configuration
- ALU_SEQ_BRANCH_EN defined: opcode 1100011 decodes as BEQ/BNE as above.
- Not defined: 1100011 is illegal, rsp_taken is constant 0, and branch-kind storage is removed.

## Test plan
- ADD: R-type f3=000, f7b5=0, rs1=5, rs2=7 -> alu_op=0010, rsp_result=12, rsp_valid 2 cycles after accept, rsp_illegal=0.
- SUB to zero with BEQ (macro on): opcode 1100011, f3=000, rs1=rs2=0x1234 -> alu_op=0110, rsp_result=0, rsp_taken=1. Repeat with f3=001 -> rsp_taken=0.
- ANDI/ORI: rs1=0xF0F0, imm=0x0FF0 -> AND gives 0x00F0, OR gives 0xFFF0. req_rs2 garbage is ignored.
- Illegal: opcode 1111111 -> rsp_illegal=1, rsp_result=0, alu_op=0000. Without the macro, branch opcode -> rsp_illegal=1.
- Backpressure: rsp_ready low 4 cycles -> rsp_* stable and req_ready=0 throughout. A queued request is accepted 1 cycle after the rsp handshake.
- Reset in EXEC: rst_n low mid-EXEC -> outputs immediately reach reset values, no rsp_valid after release, next request processed normally.
